// File: rtl/sram_arbiter.sv
// Round-robin arbiter that shares one sram_ctrl between requesters A and B.
// Only one access is in flight at a time. Completion is taken from ctrl_ready, with a bounded WAIT.
module sram_arbiter #(
    parameter int AW      = 18,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          a_req,
    input  logic          a_rw,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_done,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_rw,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_done,
    output logic [DW-1:0] b_rdata,
    output logic          ctrl_mem,
    output logic          ctrl_rw,
    output logic [AW-1:0] ctrl_addr,
    output logic [DW-1:0] ctrl_wdata,
    input  logic          ctrl_ready,
    input  logic [DW-1:0] ctrl_rdata,
    output logic          busy,
    output logic          err
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t        state_r;
    logic          owner_r;   // 1'b1 = port B owns the access in flight
    logic          last_r;    // 1'b1 = port B was granted most recently
    logic          rw_r;
    logic [3:0]    cnt_r;
    logic          a_done_r;
    logic          b_done_r;
    logic          busy_r;
    logic          err_r;
    logic [DW-1:0] a_rdata_r;
    logic [DW-1:0] b_rdata_r;
    logic          grant_s;
    logic          pick_b_s;

    // A lone requester wins; on a tie the port that was not served last wins.
    function automatic logic pick_b(input logic req_a, input logic req_b, input logic last_b);
        logic sel;
        if (req_a && req_b) begin
            sel = ~last_b;
        end else begin
            sel = req_b;
        end
        return sel;
    endfunction

    // Grant decision: only possible while idle with the controller ready.
    always_comb begin
        grant_s  = 1'b0;
        pick_b_s = 1'b0;
        if ((state_r == IDLE) && ctrl_ready && (a_req || b_req)) begin
            grant_s  = 1'b1;
            pick_b_s = pick_b(a_req, b_req, last_r);
        end else begin
            grant_s  = 1'b0;
            pick_b_s = 1'b0;
        end
    end

    // Controller command: live in the issue cycle only, otherwise parked (rw=1, addr/data zero).
    always_comb begin
        ctrl_mem   = 1'b0;
        ctrl_rw    = 1'b1;
        ctrl_addr  = {AW{1'b0}};
        ctrl_wdata = {DW{1'b0}};
        if (grant_s) begin
            ctrl_mem   = 1'b1;
            ctrl_rw    = pick_b_s ? b_rw    : a_rw;
            ctrl_addr  = pick_b_s ? b_addr  : a_addr;
            ctrl_wdata = pick_b_s ? b_wdata : a_wdata;
        end else begin
            ctrl_mem   = 1'b0;
            ctrl_rw    = 1'b1;
            ctrl_addr  = {AW{1'b0}};
            ctrl_wdata = {DW{1'b0}};
        end
    end

    // Arbitration FSM with registered done, busy, err and read-data outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            owner_r   <= 1'b0;
            last_r    <= 1'b1;
            rw_r      <= 1'b1;
            cnt_r     <= 4'd0;
            a_done_r  <= 1'b0;
            b_done_r  <= 1'b0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
            a_rdata_r <= {DW{1'b0}};
            b_rdata_r <= {DW{1'b0}};
        end else begin
            a_done_r <= 1'b0;
            b_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        owner_r <= pick_b_s;
                        last_r  <= pick_b_s;
                        rw_r    <= pick_b_s ? b_rw : a_rw;
                        cnt_r   <= 4'd0;
                        busy_r  <= 1'b1;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r + 4'd1;
                    if (ctrl_ready) begin
                        if (rw_r) begin
                            if (owner_r) begin
                                b_rdata_r <= ctrl_rdata;
                            end else begin
                                a_rdata_r <= ctrl_rdata;
                            end
                        end
                        a_done_r <= ~owner_r;
                        b_done_r <= owner_r;
                        state_r  <= DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        // Controller never came back: complete anyway and flag it.
                        err_r <= 1'b1;
                        if (rw_r) begin
                            if (owner_r) begin
                                b_rdata_r <= {DW{1'b0}};
                            end else begin
                                a_rdata_r <= {DW{1'b0}};
                            end
                        end
                        a_done_r <= ~owner_r;
                        b_done_r <= owner_r;
                        state_r  <= DONE;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign a_done  = a_done_r;
    assign b_done  = b_done_r;
    assign a_rdata = a_rdata_r;
    assign b_rdata = b_rdata_r;
    assign busy    = busy_r;
    assign err     = err_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter. A 3-cycle sram_ctrl model responds to the DUT, and a
// transaction-level reference model predicts the grant order, the read data and the latencies.
module tb_sram_arbiter;
    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          a_req, a_rw, b_req, b_rw;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_done, b_done;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ctrl_mem, ctrl_rw, ctrl_ready;
    logic [AW-1:0] ctrl_addr;
    logic [DW-1:0] ctrl_wdata, ctrl_rdata;
    logic          busy, err;

    sram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_done(b_done), .b_rdata(b_rdata),
        .ctrl_mem(ctrl_mem), .ctrl_rw(ctrl_rw), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
        .ctrl_ready(ctrl_ready), .ctrl_rdata(ctrl_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 2) return 16'hBEEF;
        return (16'(i) * 16'h0101) ^ 16'h5A5A;
    endfunction

    // sram_ctrl model: accepts when idle, ready is low for 2 cycles, and data is valid when ready returns
    logic          stall;
    int            sbusy;
    logic [3:0]    s_idx;
    logic          s_rw;
    logic [DW-1:0] s_wd, s_rdata;
    logic [DW-1:0] sram_m [16];
    assign ctrl_ready = (sbusy == 0) && !stall;
    assign ctrl_rdata = s_rdata;

    always @(posedge clk) begin
        if (!reset_n) begin
            sbusy <= 0;
            for (int i = 0; i < 16; i++) sram_m[i] <= init_val(i);
        end else if (ctrl_ready && ctrl_mem) begin
            sbusy <= 2;
            s_idx <= ctrl_addr[3:0];
            s_rw  <= ctrl_rw;
            s_wd  <= ctrl_wdata;
        end else if (sbusy == 1) begin
            sbusy <= 0;
            if (s_rw) s_rdata <= sram_m[s_idx];
            else sram_m[s_idx] <= s_wd;
        end else if (sbusy > 1) begin
            sbusy <= sbusy - 1;
        end
    end

    // Reference model and scoreboard queues
    typedef struct packed { logic rw; logic [AW-1:0] addr; logic [DW-1:0] wdata; } txn_t;
    typedef struct { logic rw; logic [AW-1:0] addr; logic [DW-1:0] wdata; int at; int gap; } iss_t;
    typedef struct { logic [DW-1:0] rdata; int lat; logic err; } don_t;

    iss_t          exp_iss[$];
    don_t          exp_a[$], exp_b[$];
    txn_t          qa[$], qb[$];
    logic          m_last, m_err;
    logic [DW-1:0] m_arv, m_brv;
    logic [DW-1:0] ref_m [16];

    task automatic model_reset();
        m_last = 1'b1;
        m_err  = 1'b0;
        m_arv  = '0;
        m_brv  = '0;
        for (int i = 0; i < 16; i++) ref_m[i] = init_val(i);
    endtask

    task automatic expect_access(input logic p, input txn_t t, input logic tmo, input int at, input int gap);
        iss_t e;
        don_t d;
        logic [DW-1:0] rv;
        e.rw = t.rw; e.addr = t.addr; e.wdata = t.wdata; e.at = at; e.gap = gap;
        exp_iss.push_back(e);
        rv = p ? m_brv : m_arv;
        if (!t.rw) ref_m[t.addr[3:0]] = t.wdata;
        else if (tmo) rv = '0;
        else rv = ref_m[t.addr[3:0]];
        if (tmo) m_err = 1'b1;
        if (p) m_brv = rv; else m_arv = rv;
        d.rdata = rv; d.lat = tmo ? 16 : 4; d.err = m_err;
        if (p) exp_b.push_back(d); else exp_a.push_back(d);
        m_last = p;
    endtask

    // Monitor: pops expectations whenever the DUT issues or completes
    int a_iss_cyc = 0, b_iss_cyc = 0, last_iss_cyc = 0;

    task automatic mon_step();
        iss_t ie;
        don_t d;
        if (ctrl_mem) begin
            if (exp_iss.size() == 0) chk("issue_expected", 32'(exp_iss.size()), 32'd1);
            else begin
                ie = exp_iss.pop_front();
                chk("issue_rw", 32'(ctrl_rw), 32'(ie.rw));
                chk("issue_addr", 32'(ctrl_addr), 32'(ie.addr));
                if (!ie.rw) chk("issue_wdata", 32'(ctrl_wdata), 32'(ie.wdata));
                if (ie.at >= 0) chk("issue_cycle", 32'(cyc), 32'(ie.at));
                if (ie.gap >= 0) chk("issue_spacing", 32'(cyc - last_iss_cyc), 32'(ie.gap));
                last_iss_cyc = cyc;
                a_iss_cyc = cyc;
                b_iss_cyc = cyc;
            end
        end else begin
            chk("park_rw", 32'(ctrl_rw), 32'd1);
            chk("park_addr", 32'(ctrl_addr), 32'd0);
            chk("park_wdata", 32'(ctrl_wdata), 32'd0);
        end
        chk("done_exclusive", 32'(a_done & b_done), 32'd0);
        if (a_done) begin
            if (exp_a.size() == 0) chk("a_done_expected", 32'(exp_a.size()), 32'd1);
            else begin
                d = exp_a.pop_front();
                chk("a_rdata", 32'(a_rdata), 32'(d.rdata));
                chk("a_latency", 32'(cyc - a_iss_cyc), 32'(d.lat));
                chk("a_err", 32'(err), 32'(d.err));
            end
        end
        if (b_done) begin
            if (exp_b.size() == 0) chk("b_done_expected", 32'(exp_b.size()), 32'd1);
            else begin
                d = exp_b.pop_front();
                chk("b_rdata", 32'(b_rdata), 32'(d.rdata));
                chk("b_latency", 32'(cyc - b_iss_cyc), 32'(d.lat));
                chk("b_err", 32'(err), 32'(d.err));
            end
        end
    endtask

    always @(negedge clk) if (reset_n) mon_step();

    // Stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t rnd_txn();
        txn_t t;
        t.rw    = 1'($urandom_range(0, 1));
        t.addr  = AW'($urandom);
        t.wdata = DW'($urandom);
        return t;
    endfunction

    task automatic drive_a(input txn_t t);
        a_rw = t.rw; a_addr = t.addr; a_wdata = t.wdata;
    endtask

    task automatic drive_b(input txn_t t);
        b_rw = t.rw; b_addr = t.addr; b_wdata = t.wdata;
    endtask

    task automatic wait_done(input logic p, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = p ? b_done : a_done;
        end
        chk("done_within_budget", 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        a_req = 1'b0; b_req = 1'b0; stall = 1'b0; reset_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'({a_done, b_done}), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_a_rdata", 32'(a_rdata), 32'd0);
        chk("rst_b_rdata", 32'(b_rdata), 32'd0);
        reset_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic run_single(input logic p, input txn_t t, input int gap);
        int c;
        for (int i = 0; i < gap; i++) tick();
        c = cyc;
        expect_access(p, t, 1'b0, c, -1);
        if (p) begin drive_b(t); b_req = 1'b1; end
        else begin drive_a(t); a_req = 1'b1; end
        tick();
        chk("busy_in_wait", 32'(busy), 32'd1);
        wait_done(p, 10);
        a_req = 1'b0; b_req = 1'b0;
        tick();
    endtask

    // Both ports hold req with qa/qb queued transactions; grants must alternate every 5 cycles
    task automatic run_both();
        int   n = qa.size();
        int   c = cyc;
        int   ia = 0, ib = 0;
        logic first = ~m_last;
        for (int k = 0; k < 2 * n; k++) begin
            logic p = (k % 2 == 0) ? first : ~first;
            expect_access(p, p ? qb[k / 2] : qa[k / 2], 1'b0, (k == 0) ? c : -1, (k == 0) ? -1 : 5);
        end
        drive_a(qa[0]); drive_b(qb[0]);
        a_req = 1'b1; b_req = 1'b1;
        for (int t = 0; t < 10 * n + 20 && (ia < n || ib < n); t++) begin
            tick();
            if (a_done) begin ia++; if (ia < n) drive_a(qa[ia]); else a_req = 1'b0; end
            if (b_done) begin ib++; if (ib < n) drive_b(qb[ib]); else b_req = 1'b0; end
        end
        chk("pair_all_done", 32'(ia + ib), 32'(2 * n));
        a_req = 1'b0; b_req = 1'b0;
        qa.delete(); qb.delete();
        tick();
    endtask

    initial begin
        txn_t t;
        int   c;
        a_req = 1'b0; a_rw = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_rw = 1'b0; b_addr = '0; b_wdata = '0;
        stall = 1'b0; reset_n = 1'b0;
        model_reset();
        do_reset();

        // single read of 0x00012 returns the controller data
        t.rw = 1'b1; t.addr = 18'h00012; t.wdata = 16'h0000;
        run_single(1'b0, t, 0);
        chk("t1_a_rdata", 32'(a_rdata), 32'h0000BEEF);

        // tie after reset: A first, then B
        do_reset();
        t.rw = 1'b0; t.addr = 18'h00001; t.wdata = 16'h1111; qa.push_back(t);
        t.rw = 1'b0; t.addr = 18'h00002; t.wdata = 16'h2222; qb.push_back(t);
        run_both();

        // fairness: three accesses per port, strictly alternating
        for (int i = 0; i < 3; i++) begin qa.push_back(rnd_txn()); qb.push_back(rnd_txn()); end
        run_both();

        // deferral: controller busy for 7 cycles while A requests
        t = rnd_txn(); t.rw = 1'b1;
        c = cyc;
        stall = 1'b1; drive_a(t); a_req = 1'b1;
        expect_access(1'b0, t, 1'b0, c + 7, -1);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) chk("defer_busy", 32'(busy), 32'd0);
            tick();
        end
        stall = 1'b0;
        wait_done(1'b0, 12);
        a_req = 1'b0;
        tick();

        // timeout: ready stuck low after a B read has issued
        t = rnd_txn(); t.rw = 1'b1;
        c = cyc;
        drive_b(t); b_req = 1'b1;
        expect_access(1'b1, t, 1'b1, c, -1);
        tick();
        stall = 1'b1;
        wait_done(1'b1, 30);
        b_req = 1'b0;
        chk("tmo_b_rdata", 32'(b_rdata), 32'd0);
        chk("tmo_err", 32'(err), 32'd1);
        stall = 1'b0;
        tick();

        // randomized traffic; err must stay set throughout
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                int n = $urandom_range(1, 4);
                for (int i = 0; i < n; i++) begin qa.push_back(rnd_txn()); qb.push_back(rnd_txn()); end
                run_both();
            end else begin
                run_single(1'($urandom_range(0, 1)), rnd_txn(), $urandom_range(0, 3));
            end
        end
        chk("err_sticky", 32'(err), 32'd1);

        // reset during WAIT aborts the access with no done
        t = rnd_txn(); t.rw = 1'b1;
        begin
            iss_t e;
            e.rw = t.rw; e.addr = t.addr; e.wdata = t.wdata; e.at = cyc; e.gap = -1;
            exp_iss.push_back(e);
        end
        drive_a(t); a_req = 1'b1;
        tick();
        a_req = 1'b0; reset_n = 1'b0;
        tick();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_a_done", 32'(a_done), 32'd0);
        chk("midrst_a_rdata", 32'(a_rdata), 32'd0);
        chk("midrst_b_rdata", 32'(b_rdata), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) tick();
        qa.push_back(rnd_txn()); qb.push_back(rnd_txn());
        run_both();

        chk("leftover_issue", 32'(exp_iss.size()), 32'd0);
        chk("leftover_a_done", 32'(exp_a.size()), 32'd0);
        chk("leftover_b_done", 32'(exp_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
